jk_button_cmd: RTL

- Upstream command stage for the JK flip-flop. Two raw pushbuttons ("set" and "clear") pass through a synchronizer and a debouncer, then a rising-edge detector.
- An arbitration FSM converts each debounced press into a one-cycle J/K command pulse that drives the flop's J and K inputs directly.
- A "set" and a "clear" press landing within a short window of each other are merged into a toggle command (J=K=1).

---
 rtl/jk_button_cmd.sv | 130 +++++++++++++
 1 files changed

// File: rtl/jk_button_cmd.sv
// Button front end for the JK flop: sync + debounce + rise detect per button, then an
// arbiter that turns each press episode into one J/K command pulse, merging near-paired presses.
module jk_button_cmd #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned CNT_W           = 5,
   parameter int unsigned PAIR_WINDOW     = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_j,
   input  logic btn_k,
   output logic j,
   output logic k,
   output logic cmd_valid,
   output logic busy
);

   localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WinLast = CNT_W'(PAIR_WINDOW - 1);

   typedef enum logic [1:0] {StIdle, StWaitPair, StEmit, StRelease} state_e;
   // Bit 0 drives J, bit 1 drives K.
   typedef enum logic [1:0] {CmdNone = 2'b00, CmdSet = 2'b01, CmdClr = 2'b10,
                             CmdToggle = 2'b11} cmd_e;

   // Channel index 0 is the J ("set") button, 1 is the K ("clear") button.
   logic [1:0]       meta_q, sync_q, deb_q, deb_dly_q;
   logic [CNT_W-1:0] cnt_q [2];
   logic [1:0]       rise;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q    <= '0;
         sync_q    <= '0;
         deb_q     <= '0;
         deb_dly_q <= '0;
         for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
      end else begin
         meta_q    <= {btn_k, btn_j};
         sync_q    <= meta_q;
         deb_dly_q <= deb_q;
         for (int i = 0; i < 2; i++) begin
            if (sync_q[i] == deb_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == DebLast) begin
               deb_q[i] <= sync_q[i];
               cnt_q[i] <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   assign rise = deb_q & ~deb_dly_q;

   state_e           state_q, state_d;
   cmd_e             cmd_q, cmd_d, pend_q, pend_d;
   logic [CNT_W-1:0] win_q, win_d;
   logic [1:0]       jk_q, jk_d;
   logic             valid_q, valid_d;
   logic             other_rise;

   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      pend_d     = pend_q;
      win_d      = win_q;
      other_rise = (pend_q == CmdSet) ? rise[1] : rise[0];
      unique case (state_q)
         StIdle: begin
            if (&rise) begin
               state_d = StEmit;
               cmd_d   = CmdToggle;
            end else if (rise[0]) begin
               state_d = StWaitPair;
               pend_d  = CmdSet;
               win_d   = '0;
            end else if (rise[1]) begin
               state_d = StWaitPair;
               pend_d  = CmdClr;
               win_d   = '0;
            end
         end
         StWaitPair: begin
            if (other_rise) begin
               state_d = StEmit;
               cmd_d   = CmdToggle;
            end else if (win_q == WinLast) begin
               state_d = StEmit;
               cmd_d   = pend_q;
            end else begin
               win_d = win_q + CNT_W'(1);
            end
         end
         StEmit: state_d = StRelease;
         StRelease: begin
            // A new episode needs both buttons debounced low.
            if (deb_q == 2'b00) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      jk_d    = (state_d == StEmit) ? cmd_d : CmdNone;
      valid_d = (state_d == StEmit);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cmd_q   <= CmdNone;
         pend_q  <= CmdNone;
         win_q   <= '0;
         jk_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         pend_q  <= pend_d;
         win_q   <= win_d;
         jk_q    <= jk_d;
         valid_q <= valid_d;
      end
   end

   assign j         = jk_q[0];
   assign k         = jk_q[1];
   assign cmd_valid = valid_q;
   assign busy      = (state_q != StIdle);

endmodule
